// File: rtl/window_gen_pkg.sv
// Shared types and constants for the 3x3 window generator.
package window_gen_pkg;

    localparam int unsigned WIN_TAPS = 9;
    localparam int unsigned WIN_DIM  = 3;

    // Row-major tap indices: top-left, top-right, middle-right, centre, bottom-right.
    localparam int unsigned TAP_TL = 0;
    localparam int unsigned TAP_TR = 2;
    localparam int unsigned TAP_MR = 5;
    localparam int unsigned TAP_C  = 4;
    localparam int unsigned TAP_BR = 8;

    typedef enum logic {
        PRIME  = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/window_gen_line_buf.sv
// One image line of storage: synchronous write, combinational read at the same address.
module window_gen_line_buf #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are never cleared; the consumer keeps stale lines from reaching its output.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/window_gen_3x3.sv
// Raster pixel stream to 3x3 window stream with two line buffers and a valid/ready output.
// Optional WINDOW_GEN_MARKERS_EN adds registered end-of-line / end-of-frame window markers.
module window_gen_3x3
    import window_gen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_WIDTH  = 64,
    parameter int unsigned IMG_HEIGHT = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DATA_WIDTH-1:0]          pix_data,
    input  logic                           pix_sof,
    input  logic                           pix_valid,
    output logic                           pix_ready,
    output logic [DATA_WIDTH*WIN_TAPS-1:0] win_data,
    output logic                           win_valid,
`ifdef WINDOW_GEN_MARKERS_EN
    output logic                           win_eol,
    output logic                           win_eof,
`endif
    input  logic                           win_ready
);

    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
    localparam int unsigned WIN_W = DATA_WIDTH * WIN_TAPS;

    state_t                state_q;
    state_t                state_d;
    logic [COL_W-1:0]      col_q;
    logic [ROW_W-1:0]      row_q;
    logic [COL_W-1:0]      acc_col_c;
    logic [ROW_W-1:0]      acc_row_c;
    logic                  accept_c;
    logic                  last_col_c;
    logic                  last_row_c;
    logic                  win_fire_c;
    logic [DATA_WIDTH-1:0] lb0_rd;
    logic [DATA_WIDTH-1:0] lb1_rd;
    logic [WIN_W-1:0]      sr_q;
    logic [WIN_W-1:0]      sr_d;

    assign pix_ready = !win_valid || win_ready;
    assign accept_c  = pix_valid && pix_ready;

    // Position of the pixel being accepted; sof resynchronises it to the frame origin.
    assign acc_col_c  = pix_sof ? '0 : col_q;
    assign acc_row_c  = pix_sof ? '0 : row_q;
    assign last_col_c = (acc_col_c == COL_W'(IMG_WIDTH - 1));
    assign last_row_c = (acc_row_c == ROW_W'(IMG_HEIGHT - 1));

    // lb0 holds row r-2, lb1 holds row r-1; each accept ages a column by one row.
    window_gen_line_buf #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (DATA_WIDTH)
    ) u_lb0 (
        .clk   (clk),
        .wr_en (accept_c),
        .addr  (acc_col_c),
        .wdata (lb1_rd),
        .rdata (lb0_rd)
    );

    window_gen_line_buf #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (DATA_WIDTH)
    ) u_lb1 (
        .clk   (clk),
        .wr_en (accept_c),
        .addr  (acc_col_c),
        .wdata (pix_data),
        .rdata (lb1_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PRIME;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept_c) begin
            case (state_q)
                PRIME: begin
                    if (!pix_sof && last_col_c && (acc_row_c == ROW_W'(1))) begin
                        state_d = STREAM;
                    end
                end
                STREAM: begin
                    if (pix_sof || (last_col_c && last_row_c)) begin
                        state_d = PRIME;
                    end
                end
                default: state_d = PRIME;
            endcase
        end
    end

    // Window emission and the next shift-register contents (one new column per accept).
    always_comb begin
        win_fire_c = accept_c && !pix_sof && (state_q == STREAM) && (acc_col_c >= COL_W'(2));
        sr_d       = sr_q;
        for (int r = 0; r < int'(WIN_DIM); r++) begin
            sr_d[(TAP_TL + r*3)*DATA_WIDTH +: DATA_WIDTH]     = sr_q[(TAP_TL + r*3 + 1)*DATA_WIDTH +: DATA_WIDTH];
            sr_d[(TAP_TL + r*3 + 1)*DATA_WIDTH +: DATA_WIDTH] = sr_q[(TAP_TL + r*3 + 2)*DATA_WIDTH +: DATA_WIDTH];
        end
        sr_d[TAP_TR*DATA_WIDTH +: DATA_WIDTH] = lb0_rd;
        sr_d[TAP_MR*DATA_WIDTH +: DATA_WIDTH] = lb1_rd;
        sr_d[TAP_BR*DATA_WIDTH +: DATA_WIDTH] = pix_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
            sr_q  <= '0;
        end else if (accept_c) begin
            sr_q <= sr_d;
            if (last_col_c) begin
                col_q <= '0;
                row_q <= last_row_c ? '0 : acc_row_c + ROW_W'(1);
            end else begin
                col_q <= acc_col_c + COL_W'(1);
                row_q <= acc_row_c;
            end
        end
    end

    // Output register: a new window wins over a drain in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            win_data  <= '0;
`ifdef WINDOW_GEN_MARKERS_EN
            win_eol   <= 1'b0;
            win_eof   <= 1'b0;
`endif
        end else if (win_fire_c) begin
            win_valid <= 1'b1;
            win_data  <= sr_d;
`ifdef WINDOW_GEN_MARKERS_EN
            win_eol   <= last_col_c;
            win_eof   <= last_col_c && last_row_c;
`endif
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Randomised self-checking bench for window_gen_3x3 against a frame-array reference model.
module tb_window_gen_3x3;

    localparam int W = 5;
    localparam int H = 4;

    typedef struct {
        logic [71:0] data;
        logic        eol;
        logic        eof;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pix_data = '0;
    logic        pix_sof = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [71:0] win_data;
    logic        win_valid;
    logic        win_ready = 1'b1;
`ifdef WINDOW_GEN_MARKERS_EN
    logic        win_eol;
    logic        win_eof;
`endif

    window_gen_3x3 #(
        .DATA_WIDTH (8),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_data  (pix_data),
        .pix_sof   (pix_sof),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .win_data  (win_data),
        .win_valid (win_valid),
`ifdef WINDOW_GEN_MARKERS_EN
        .win_eol   (win_eol),
        .win_eof   (win_eof),
`endif
        .win_ready (win_ready)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];
    logic [71:0] got_q[$];
    logic [7:0]  img [H][W];
    int          mr = 0;
    int          mc = 0;
    int          acc_total = 0;
    int          first_valid_acc = -1;
    int          stall_left = 0;
    bit          rdy_rand = 0;
    bit          gaps = 0;
    bit          held = 0;
    logic [71:0] held_data = '0;

    localparam logic [71:0] WIN_FIRST  = 72'h22_21_20_12_11_10_02_01_00;
    localparam logic [71:0] WIN_SECOND = 72'h23_22_21_13_12_11_03_02_01;
    localparam logic [71:0] WIN_LAST   = 72'h34_33_32_24_23_22_14_13_12;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: store the frame as a 2D image and cut windows out of it directly.
    task automatic model_accept(input logic [7:0] d, input logic s);
        exp_t e;
        if (s) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = d;
        acc_total++;
        if (mr >= 2 && mc >= 2) begin
            e.data = '0;
            for (int i = 0; i < 9; i++) begin
                e.data[8*i +: 8] = img[mr - 2 + i/3][mc - 2 + i%3];
            end
            e.eol = (mc == W - 1);
            e.eof = (mc == W - 1) && (mr == H - 1);
            exp_q.push_back(e);
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic s, output logic acc);
        exp_t e;
        @(negedge clk);
        pix_valid = v;
        pix_data  = d;
        pix_sof   = s;
        if (stall_left > 0 && win_valid) begin
            win_ready = 1'b0;
            stall_left--;
        end else if (rdy_rand) begin
            win_ready = ($urandom_range(0, 2) != 0);
        end else begin
            win_ready = 1'b1;
        end
        #1;
        check("win_valid", win_valid, exp_q.size() != 0);
        check("pix_ready", pix_ready, !win_valid || win_ready);
        if (held) check("win_hold", win_data, held_data);
        if (win_valid && first_valid_acc < 0) first_valid_acc = acc_total;
        if (win_valid && win_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("win_data", win_data, e.data);
`ifdef WINDOW_GEN_MARKERS_EN
            check("win_eol", win_eol, e.eol);
            check("win_eof", win_eof, e.eof);
`endif
            got_q.push_back(win_data);
        end
        held      = win_valid && !win_ready;
        held_data = win_data;
        acc = v && pix_ready;
        if (acc) model_accept(d, s);
    endtask

    task automatic send_pixel(input logic [7:0] d, input logic s);
        logic acc = 1'b0;
        int   tries = 0;
        while (!acc) begin
            step(gaps ? ($urandom_range(0, 3) != 0) : 1'b1, d, s, acc);
            tries++;
            if (!acc && tries > 500) begin
                check("pix_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic send_frame(input bit sof_first, input bit rnd, input int first_idx, input int last_idx);
        for (int i = first_idx; i <= last_idx; i++) begin
            send_pixel(rnd ? 8'($urandom_range(0, 255)) : 8'((i / W) * 16 + (i % W)),
                       sof_first && (i == 0));
        end
    endtask

    task automatic drain();
        logic acc;
        int   tries = 0;
        while ((exp_q.size() != 0 || win_valid) && tries < 500) begin
            step(1'b0, 8'h00, 1'b0, acc);
            tries++;
        end
        check("drain_done", exp_q.size() == 0 && !win_valid, 1);
    endtask

    task automatic new_test();
        got_q.delete();
        first_valid_acc = -1;
        acc_total = 0;
    endtask

    initial begin
        #1;
        check("rst_win_valid", win_valid, 0);
        check("rst_win_data", win_data, 0);
        check("rst_pix_ready", pix_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // 1/2: clean frame, first-window latency and boundary windows
        new_test();
        send_frame(1, 0, 0, W*H - 1);
        drain();
        check("t1_count", got_q.size(), 6);
        if (got_q.size() == 6) begin
            check("t1_first", got_q[0], WIN_FIRST);
            check("t1_last", got_q[5], WIN_LAST);
        end
        check("t2_accepts_before_valid", first_valid_acc, 13);

        // 3: back-pressure on the first window
        new_test();
        stall_left = 10;
        send_frame(1, 0, 0, W*H - 1);
        drain();
        check("t3_count", got_q.size(), 6);
        if (got_q.size() >= 2) begin
            check("t3_first", got_q[0], WIN_FIRST);
            check("t3_second", got_q[1], WIN_SECOND);
        end

        // 4: random gaps and back-pressure over three back-to-back frames
        new_test();
        rdy_rand = 1;
        gaps = 1;
        for (int f = 0; f < 3; f++) send_frame(f == 0, 1, 0, W*H - 1);
        drain();
        check("t4_count", got_q.size(), 18);
        rdy_rand = 0;
        gaps = 0;

        // 5: sof resync in the middle of a frame at (2,3)
        new_test();
        send_frame(1, 0, 0, 2*W + 2);
        send_pixel(8'h00, 1'b1);
        send_frame(0, 0, 1, W*H - 1);
        drain();
        check("t5_count", got_q.size(), 7);
        if (got_q.size() == 7) begin
            check("t5_pending", got_q[0], WIN_FIRST);
            check("t5_resync_first", got_q[1], WIN_FIRST);
            check("t5_resync_last", got_q[6], WIN_LAST);
        end

        // 6: asynchronous reset while a window is held
        new_test();
        send_frame(1, 0, 0, 2*W + 1);
        stall_left = 100;
        send_frame(0, 0, 2*W + 2, 2*W + 2);
        begin
            logic acc;
            step(1'b0, 8'h00, 1'b0, acc);
        end
        check("t6_pre_valid", win_valid, 1);
        @(negedge clk);
        pix_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t6_rst_win_valid", win_valid, 0);
        check("t6_rst_pix_ready", pix_ready, 1);
        stall_left = 0;
        exp_q.delete();
        held = 0;
        mr = 0;
        mc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        new_test();
        send_frame(0, 0, 0, W*H - 1);
        drain();
        check("t6_count", got_q.size(), 6);
        if (got_q.size() == 6) begin
            check("t6_first", got_q[0], WIN_FIRST);
            check("t6_last", got_q[5], WIN_LAST);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
